mine_reveal_seq: RTL and testbench
==================================

// Module: mine_reveal_seq
// PURPOSE
// - Game-over mine reveal sequencer; directly upstream of draw_mine.
// - On game_lost, shows the clicked mine first. Then scans the mine map row-major and presents each
//   remaining mine on mine_ind_x/y with explode=1 for FRAMES_PER_MINE frames.
// - Pulses mark_we per shown mine so the board map latches it as revealed.
// PARAMETERS
// - FRAMES_PER_MINE  4  vsync frames each mine is held; legal range 1..255
// PORTS
// - clk          in   1  pixel clock
// - rst          in   1  reset; asynchronous, active-low (asserted when 0)
// - level        in   2  0=menu, 1=8x8, 2=16x16, 3=24x24 board; sampled at trigger
// - game_lost    in   1  one-cycle pulse: mine hit
// - hit_x        in   5  1-based column of hit mine; valid with game_lost
// - hit_y        in   5  1-based row of hit mine; valid with game_lost
// - restart      in   1  one-cycle pulse: abort/clear sequence
// - vsync        in   1  VGA vsync from timing chain; rising edge = frame tick
// - map_x        out  5  mine-map read column, 1-based
// - map_y        out  5  mine-map read row, 1-based
// - map_rd_data  in   1  mine present at (map_x,map_y); valid 1 cycle after address
// - mine_ind_x   out  5  current mine column to draw_mine, 1-based
// - mine_ind_y   out  5  current mine row to draw_mine, 1-based
// - explode      out  1  draw enable to draw_mine
// - mark_we      out  1  one-cycle pulse: mark (mine_ind_x,mine_ind_y) revealed
// - busy         out  1  sequence in progress
// - done         out  1  all mines shown; held until restart
// BEHAVIOUR
// - Reset values: map_x=map_y=1, mine_ind_x=mine_ind_y=1, explode=0, mark_we=0, busy=0, done=0.
//   State=IDLE; frame counter=0; vsync_d=0.
// - Outputs are registered. Frame tick = vsync & ~vsync_d, with vsync_d registered.
// - dim = board_dim(level_q): 8/16/24. level_q is latched on the game_lost accepted in IDLE.
// - FSM:
//   - IDLE: on game_lost && level!=0 -> HIT next cycle. Load mine_ind=hit. explode=1, busy=1,
//     mark_we=1 for 1 cycle, frame_cnt=0. game_lost with level==0 is ignored.
//   - HIT/SHOW: count frame ticks. When frame_cnt reaches FRAMES_PER_MINE -> SCAN_RD.
//     On leaving HIT, scan starts at (1,1). On leaving SHOW, the scan advances by one cell.
//     explode stays 1 and mine_ind holds.
//   - SCAN_RD: map_x/y = scan cell (address presented) -> SCAN_CHK.
//   - SCAN_CHK: sample map_rd_data.
//     - If 1 and cell!=hit: mine_ind<=cell, mark_we pulse, frame_cnt=0 -> SHOW.
//     - Otherwise advance the cell -> SCAN_RD.
//   - Advance: x++. When x==dim, x=1 and y++. Past (dim,dim) -> DONE.
//   - DONE: busy=0, done=1, explode=1; last mine stays drawn.
// - restart in any state -> IDLE next cycle: explode=0, done=0, busy=0, counters cleared.
//   restart has priority over game_lost in the same cycle.
// - game_lost while busy or done: ignored. level changes while busy: ignored; level_q is used.
// - hit equal to a scanned mine: skipped, so not shown twice.
//   Map with zero other mines: HIT -> scan -> DONE.
// - Scan cost: 2 cycles per cell. A 24x24 board scans in ~1152 clk plus hold frames.
// - Async reset mid-sequence: all outputs go to reset values immediately. No resume.
// STRUCTURE
// - Package reveal_pkg: typedef enum {IDLE,HIT,SCAN_RD,SCAN_CHK,SHOW,DONE} reveal_state_t;
//   function board_dim(level)->5b; localparams DIM_L1=8, DIM_L2=16, DIM_L3=24.
// - Sub-module frame_tick_gen holds vsync edge detect and the frame counter:
//   - inputs: clr, vsync. outputs: tick, expired.
// - Top contains the FSM, scan counters and output registers.
// TESTING
// - level=1, FRAMES_PER_MINE=2, mines at (3,2),(8,8), game_lost hit=(3,2):
//   -> (3,2) held 2 ticks, then (8,8) held 2 ticks, then done=1. mark_we pulses exactly 2.
// - level=3, mine only at (24,24)=hit -> hit shown, full scan, DONE. mark_we pulses once.
// - level=0, game_lost -> no state change, explode=0, busy=0.
// - restart during SHOW of second mine -> next cycle explode=0, busy=0.
//   A following game_lost is accepted.
// - game_lost pulsed while busy, and level changed 1->3 mid-scan -> ignored;
//   scan stops at (8,8) boundary.
// - rst=0 mid SCAN_CHK -> all outputs at reset values without a clock edge.
//   Release -> stays IDLE.

Source files
------------

// File: rtl/mine_reveal_seq_pkg.sv
// Shared types and board geometry for the game-over mine reveal sequencer.
package reveal_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HIT,
    SCAN_RD,
    SCAN_CHK,
    SHOW,
    DONE
  } reveal_state_t;

  localparam logic [4:0] DIM_L1     = 5'd8;
  localparam logic [4:0] DIM_L2     = 5'd16;
  localparam logic [4:0] DIM_L3     = 5'd24;
  localparam logic [4:0] CELL_FIRST = 5'd1;

  // Level 0 (menu) never starts a sequence, so its value here is never used.
  function automatic logic [4:0] board_dim(input logic [1:0] level);
    logic [4:0] dim;
    case (level)
      2'd1:    dim = DIM_L1;
      2'd2:    dim = DIM_L2;
      2'd3:    dim = DIM_L3;
      default: dim = DIM_L1;
    endcase
    return dim;
  endfunction

endpackage

// File: rtl/mine_reveal_seq_frame_tick_gen.sv
// Vsync rising-edge detector plus a per-mine frame counter.
// o_expired flags that the current frame is the last one of the hold, so tick & expired ends it.
module frame_tick_gen #(
  parameter int unsigned FRAMES_PER_MINE = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_vsync,
  output logic o_tick,
  output logic o_expired
);

  localparam logic [7:0] LAST_FRAME = 8'(FRAMES_PER_MINE - 1);

  logic       r_vsync_d;
  logic [7:0] r_frame_cnt;

  assign o_tick    = i_vsync & ~r_vsync_d;
  assign o_expired = (r_frame_cnt >= LAST_FRAME);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vsync_d   <= 1'b0;
      r_frame_cnt <= 8'd0;
    end else begin
      r_vsync_d <= i_vsync;
      if (i_clr) begin
        r_frame_cnt <= 8'd0;
      end else if (o_tick && (r_frame_cnt != 8'hFF)) begin
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/mine_reveal_seq.sv
// Game-over mine reveal: shows the clicked mine, then every other mine in row-major order,
// each held for FRAMES_PER_MINE frames, pulsing o_mark_we once per mine shown.
module mine_reveal_seq
  import reveal_pkg::*;
#(
  parameter int unsigned FRAMES_PER_MINE = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_level,
  input  logic       i_game_lost,
  input  logic [4:0] i_hit_x,
  input  logic [4:0] i_hit_y,
  input  logic       i_restart,
  input  logic       i_vsync,
  output logic [4:0] o_map_x,
  output logic [4:0] o_map_y,
  input  logic       i_map_rd_data,
  output logic [4:0] o_mine_ind_x,
  output logic [4:0] o_mine_ind_y,
  output logic       o_explode,
  output logic       o_mark_we,
  output logic       o_busy,
  output logic       o_done
);

  reveal_state_t r_state;
  logic [1:0]    r_level_q;
  logic [4:0]    r_hit_x;
  logic [4:0]    r_hit_y;
  logic [4:0]    r_scan_x;
  logic [4:0]    r_scan_y;
  logic [4:0]    r_mine_x;
  logic [4:0]    r_mine_y;
  logic          r_explode;
  logic          r_mark_we;
  logic          r_busy;
  logic          r_done;

  logic       w_clr;
  logic       w_tick;
  logic       w_expired;
  logic       w_hold_done;
  logic [4:0] w_dim;
  logic       w_last_x;
  logic       w_last_cell;
  logic       w_scan_is_hit;
  logic [4:0] w_next_x;
  logic [4:0] w_next_y;

  // The frame counter only runs while a mine is on display; everywhere else it sits at zero.
  assign w_clr = i_restart || !((r_state == HIT) || (r_state == SHOW));

  frame_tick_gen #(
    .FRAMES_PER_MINE(FRAMES_PER_MINE)
  ) u_frame_tick (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clr    (w_clr),
    .i_vsync  (i_vsync),
    .o_tick   (w_tick),
    .o_expired(w_expired)
  );

  assign w_hold_done   = w_tick && w_expired;
  assign w_dim         = board_dim(r_level_q);
  assign w_last_x      = (r_scan_x == w_dim);
  assign w_last_cell   = w_last_x && (r_scan_y == w_dim);
  assign w_scan_is_hit = (r_scan_x == r_hit_x) && (r_scan_y == r_hit_y);
  assign w_next_x      = w_last_x ? CELL_FIRST : (r_scan_x + 5'd1);
  assign w_next_y      = w_last_x ? (r_scan_y + 5'd1) : r_scan_y;

  // The scan cell doubles as the map read address, so it is stable for both scan cycles.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_level_q <= 2'd0;
      r_hit_x   <= CELL_FIRST;
      r_hit_y   <= CELL_FIRST;
      r_scan_x  <= CELL_FIRST;
      r_scan_y  <= CELL_FIRST;
      r_mine_x  <= CELL_FIRST;
      r_mine_y  <= CELL_FIRST;
      r_explode <= 1'b0;
      r_mark_we <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_mark_we <= 1'b0;
      if (i_restart) begin
        r_state   <= IDLE;
        r_scan_x  <= CELL_FIRST;
        r_scan_y  <= CELL_FIRST;
        r_mine_x  <= CELL_FIRST;
        r_mine_y  <= CELL_FIRST;
        r_explode <= 1'b0;
        r_busy    <= 1'b0;
        r_done    <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (i_game_lost && (i_level != 2'd0)) begin
              r_state   <= HIT;
              r_level_q <= i_level;
              r_hit_x   <= i_hit_x;
              r_hit_y   <= i_hit_y;
              r_mine_x  <= i_hit_x;
              r_mine_y  <= i_hit_y;
              r_explode <= 1'b1;
              r_busy    <= 1'b1;
              r_mark_we <= 1'b1;
            end
          end
          HIT: begin
            if (w_hold_done) begin
              r_scan_x <= CELL_FIRST;
              r_scan_y <= CELL_FIRST;
              r_state  <= SCAN_RD;
            end
          end
          SCAN_RD: begin
            r_state <= SCAN_CHK;
          end
          SCAN_CHK: begin
            // The clicked mine was already shown first, so it is skipped here.
            if (i_map_rd_data && !w_scan_is_hit) begin
              r_mine_x  <= r_scan_x;
              r_mine_y  <= r_scan_y;
              r_mark_we <= 1'b1;
              r_state   <= SHOW;
            end else if (w_last_cell) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_scan_x <= w_next_x;
              r_scan_y <= w_next_y;
              r_state  <= SCAN_RD;
            end
          end
          SHOW: begin
            if (w_hold_done) begin
              if (w_last_cell) begin
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_state <= DONE;
              end else begin
                r_scan_x <= w_next_x;
                r_scan_y <= w_next_y;
                r_state  <= SCAN_RD;
              end
            end
          end
          DONE: begin
            r_state <= DONE;
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  assign o_map_x      = r_scan_x;
  assign o_map_y      = r_scan_y;
  assign o_mine_ind_x = r_mine_x;
  assign o_mine_ind_y = r_mine_y;
  assign o_explode    = r_explode;
  assign o_mark_we    = r_mark_we;
  assign o_busy       = r_busy;
  assign o_done       = r_done;

endmodule

// File: tb/tb_mine_reveal_seq.sv
// Randomized scoreboard bench: expected reveal order comes from a row-major walk of the mine map.
module tb_mine_reveal_seq;

  localparam int N = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] level = 2'd0;
  logic       game_lost = 1'b0;
  logic [4:0] hit_x = 5'd1;
  logic [4:0] hit_y = 5'd1;
  logic       restart = 1'b0;
  logic       vsync = 1'b0;
  logic [4:0] map_x, map_y;
  logic       map_rd_data = 1'b0;
  logic [4:0] ind_x, ind_y;
  logic       explode, mark_we, busy, done;

  logic mine_map [0:31][0:31];

  int n_tests = 0;
  int n_fail = 0;
  int marks_seen = 0;
  int dones_seen = 0;
  logic [9:0] exp_mark_q[$];
  logic [9:0] exp_done_q[$];

  always #5 clk = ~clk;

  mine_reveal_seq #(.FRAMES_PER_MINE(N)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_level      (level),
    .i_game_lost  (game_lost),
    .i_hit_x      (hit_x),
    .i_hit_y      (hit_y),
    .i_restart    (restart),
    .i_vsync      (vsync),
    .o_map_x      (map_x),
    .o_map_y      (map_y),
    .i_map_rd_data(map_rd_data),
    .o_mine_ind_x (ind_x),
    .o_mine_ind_y (ind_y),
    .o_explode    (explode),
    .o_mark_we    (mark_we),
    .o_busy       (busy),
    .o_done       (done)
  );

  // Mine map RAM with a one-cycle registered read.
  always @(posedge clk) map_rd_data <= mine_map[map_y][map_x];

  function automatic void check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  // Frame source: rising edges are always at least 5 clocks apart.
  initial begin
    forever begin
      repeat ($urandom_range(3, 8)) @(posedge clk);
      #1 vsync = 1'b1;
      repeat ($urandom_range(2, 5)) @(posedge clk);
      #1 vsync = 1'b0;
    end
  end

  // Monitor: pops the scoreboard on every mark_we / done rise and measures each hold in frames.
  logic       vs_prev = 1'b0, prev_mark = 1'b0, prev_done = 1'b0;
  bit         win_open = 1'b0;
  logic [4:0] win_x, win_y;
  int         win_ticks = 0;
  logic [9:0] e;

  always @(negedge clk) begin
    if (!rst_n) begin
      vs_prev = 1'b0; prev_mark = 1'b0; prev_done = 1'b0; win_open = 1'b0;
    end else begin
      if (win_open && (mark_we || done || !explode || map_x != win_x || map_y != win_y)) begin
        if (explode) check("hold_ticks", win_ticks, N);
        win_open = 1'b0;
      end
      if (mark_we) begin
        check("mark_we_width", int'(prev_mark), 0);
        if (exp_mark_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_mark: got (%0d,%0d), expected no mark", ind_x, ind_y);
        end else begin
          e = exp_mark_q.pop_front();
          check("mark_x", int'(ind_x), int'(e[4:0]));
          check("mark_y", int'(ind_y), int'(e[9:5]));
          check("mark_explode", int'(explode), 1);
          check("mark_busy", int'(busy), 1);
        end
        marks_seen++;
        $display("[TB] mark mine (%0d,%0d)", ind_x, ind_y);
        win_open = 1'b1; win_x = map_x; win_y = map_y; win_ticks = 0;
      end
      if (done && !prev_done) begin
        check("marks_left_at_done", exp_mark_q.size(), 0);
        if (exp_done_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_done: got done=1, expected no sequence end");
        end else begin
          e = exp_done_q.pop_front();
          check("done_ind_x", int'(ind_x), int'(e[4:0]));
          check("done_ind_y", int'(ind_y), int'(e[9:5]));
          check("done_busy", int'(busy), 0);
          check("done_explode", int'(explode), 1);
        end
        dones_seen++;
        $display("[TB] done, last mine (%0d,%0d)", ind_x, ind_y);
      end
      if (win_open && vsync && !vs_prev) win_ticks++;
      vs_prev = vsync; prev_mark = mark_we; prev_done = done;
    end
  end

  task automatic clear_map();
    for (int y = 0; y < 32; y++)
      for (int x = 0; x < 32; x++) mine_map[y][x] = 1'b0;
  endtask

  task automatic random_map(input int pct);
    clear_map();
    for (int y = 1; y <= 24; y++)
      for (int x = 1; x <= 24; x++) mine_map[y][x] = ($urandom_range(0, 99) < pct);
  endtask

  // Reference: the hit first, then every other mine of the dim x dim board in reading order.
  task automatic start_seq(input int lvl, input int hx, input int hy);
    int dim;
    logic [9:0] last;
    dim = (lvl == 1) ? 8 : (lvl == 2) ? 16 : 24;
    last = {5'(hy), 5'(hx)};
    exp_mark_q.push_back(last);
    for (int y = 1; y <= dim; y++)
      for (int x = 1; x <= dim; x++)
        if (mine_map[y][x] && !(x == hx && y == hy)) begin
          last = {5'(y), 5'(x)};
          exp_mark_q.push_back(last);
        end
    exp_done_q.push_back(last);
    @(posedge clk);
    #1 level = 2'(lvl); hit_x = 5'(hx); hit_y = 5'(hy); game_lost = 1'b1;
    @(posedge clk);
    #1 game_lost = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int start, k;
    start = dones_seen; k = 0;
    while (dones_seen == start && k < budget) begin
      @(posedge clk); k++;
    end
    if (dones_seen == start) begin
      n_tests++; n_fail++;
      $display("FAIL done_timeout: got no done in %0d cycles, expected done", budget);
    end
  endtask

  task automatic do_restart();
    @(posedge clk);
    exp_mark_q.delete(); exp_done_q.delete();
    #1 restart = 1'b1;
    @(posedge clk);
    #1 restart = 1'b0;
    check("restart_explode", int'(explode), 0);
    check("restart_busy", int'(busy), 0);
    check("restart_done", int'(done), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_map_x"}, int'(map_x), 1);
    check({tag, "_map_y"}, int'(map_y), 1);
    check({tag, "_ind_x"}, int'(ind_x), 1);
    check({tag, "_ind_y"}, int'(ind_y), 1);
    check({tag, "_explode"}, int'(explode), 0);
    check({tag, "_mark_we"}, int'(mark_we), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
  endtask

  task automatic random_run(input int lvl, input int pct);
    int dim, hx, hy;
    dim = (lvl == 1) ? 8 : (lvl == 2) ? 16 : 24;
    random_map(pct);
    hx = $urandom_range(1, dim); hy = $urandom_range(1, dim);
    mine_map[hy][hx] = 1'b1;
    start_seq(lvl, hx, hy);
    wait_done(9000);
    do_restart();
  endtask

  initial begin
    int m0, k, hx, hy;
    clear_map();
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 check_reset_outputs("post_reset");

    // Hit (3,2) plus one more mine in the bottom corner of the 8x8 board.
    mine_map[2][3] = 1'b1; mine_map[8][8] = 1'b1;
    m0 = marks_seen;
    start_seq(1, 3, 2);
    wait_done(2000);
    check("l1_mark_count", marks_seen - m0, 2);
    repeat (5) @(posedge clk);
    #1 check("done_held", int'(done), 1);
    check("done_held_busy", int'(busy), 0);
    do_restart();

    // Only mine is the hit in the last cell of the 24x24 board.
    clear_map(); mine_map[24][24] = 1'b1;
    m0 = marks_seen;
    start_seq(3, 24, 24);
    wait_done(5000);
    check("l3_mark_count", marks_seen - m0, 1);
    do_restart();

    // Menu level: game_lost must be ignored.
    m0 = marks_seen;
    @(posedge clk);
    #1 level = 2'd0; hit_x = 5'd2; hit_y = 5'd2; game_lost = 1'b1;
    @(posedge clk);
    #1 game_lost = 1'b0;
    repeat (20) @(posedge clk);
    #1 check("menu_busy", int'(busy), 0);
    check("menu_explode", int'(explode), 0);
    check("menu_marks", marks_seen - m0, 0);

    // Restart while the second mine is on display, then a fresh sequence is accepted.
    random_map(8);
    mine_map[1][2] = 1'b1; mine_map[3][5] = 1'b1; mine_map[10][10] = 1'b1;
    m0 = marks_seen; k = 0;
    start_seq(2, 10, 10);
    while (marks_seen < m0 + 2 && k < 3000) begin
      @(posedge clk); k++;
    end
    check("second_mark_reached", int'(marks_seen >= m0 + 2), 1);
    do_restart();
    random_run(2, 10);

    // game_lost and a level change while busy are ignored; scan stays on the 8x8 board.
    random_map(15);
    hx = $urandom_range(1, 8); hy = $urandom_range(1, 8);
    mine_map[hy][hx] = 1'b1;
    start_seq(1, hx, hy);
    repeat (40) @(posedge clk);
    #1 level = 2'd3; hit_x = 5'd20; hit_y = 5'd20; game_lost = 1'b1;
    @(posedge clk);
    #1 game_lost = 1'b0;
    wait_done(4000);
    do_restart();

    // Asynchronous reset in the middle of a scan.
    random_map(10);
    mine_map[12][12] = 1'b1;
    start_seq(3, 12, 12);
    repeat (300) @(posedge clk);
    #3 rst_n = 1'b0;
    exp_mark_q.delete(); exp_done_q.delete();
    #1 check_reset_outputs("async_reset");
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1 check("after_reset_busy", int'(busy), 0);
    check("after_reset_explode", int'(explode), 0);
    check("after_reset_done", int'(done), 0);

    for (int r = 0; r < 5; r++) random_run($urandom_range(1, 3), $urandom_range(3, 15));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
